// File: rtl/clk_pkg.sv
// Shared definitions for the clock/reset sequencer: state encoding, reset polarity, width helper.
// Latency: n/a (package only).
// Backpressure: n/a.
package clk_pkg;

    // Encoding is visible on seq_state, so the values are fixed.
    typedef enum logic [2:0] {
        DCM_RST   = 3'd0,
        WAIT_LOCK = 3'd1,
        RELEASE   = 3'd2,
        RUN       = 3'd3
    } seq_state_t;

    // Polarity of the downstream active-low domain resets.
    localparam logic RESET_ENABLE  = 1'b0;
    localparam logic RESET_DISABLE = 1'b1;

    // Number of bits needed to represent values 0..value-1 (minimum 1).
    function automatic int clog2(input int value);
        int w;
        w = 1;
        while ((1 << w) < value) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/sync_debounce.sv
// Two-flop synchroniser with optional debounce; DEBOUNCE=0 passes the synced level through.
// Latency: 2 cycles to the synced level; a debounced request pulses after DEBOUNCE further cycles high.
// Backpressure: none; free-running, the pulse fires once per continuous high period.
//
// Ports: clk, rst_n (async active-low), din (asynchronous input),
//        dout (synced level when DEBOUNCE=0, else one-cycle request pulse).
module sync_debounce
    import clk_pkg::*;
#(
    parameter int DEBOUNCE = 0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout
);

    logic sync_q1;
    logic sync_q2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
        end else begin
            sync_q1 <= din;
            sync_q2 <= sync_q1;
        end
    end

    generate
        if (DEBOUNCE == 0) begin : g_bypass
            assign dout = sync_q2;
        end else begin : g_debounce
            localparam int DW = clog2(DEBOUNCE + 1);
            localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE - 1);
            localparam logic [DW-1:0] DEB_FULL = DW'(DEBOUNCE);

            logic [DW-1:0] deb_cnt;

            // Counter parks one past the pulse value, so a held switch
            // produces exactly one request until it is released.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    deb_cnt <= '0;
                end else if (!sync_q2) begin
                    deb_cnt <= '0;
                end else if (deb_cnt != DEB_FULL) begin
                    deb_cnt <= deb_cnt + 1'b1;
                end
            end

            assign dout = sync_q2 && (deb_cnt == DEB_LAST);
        end
    endgenerate

endmodule

// File: rtl/clk_rst_seq.sv
// DCM reset / lock qualification / staggered domain-reset release sequencer with abort and retry.
// Latency: power-up to all_ready = DCM_RST_CYC + LOCK_STABLE + NUM_DOMAIN*STAGGER + 1 cycles.
// Backpressure: none; lock loss or a debounced switch request aborts to DCM_RST at any time.
//
// Ports: clk, reset_ (async active-low), reset_sw (raw pushbutton), locked (async DCM lock),
//        dcm_reset, domain_reset_[NUM_DOMAIN] (active-low), all_ready, lock_loss_cnt, seq_state.
module clk_rst_seq
    import clk_pkg::*;
#(
    parameter int NUM_DOMAIN   = 3,
    parameter int DCM_RST_CYC  = 4,
    parameter int LOCK_STABLE  = 16,
    parameter int LOCK_TIMEOUT = 1024,
    parameter int STAGGER      = 8,
    parameter int DEBOUNCE     = 32,
    parameter int CNT_W        = 8
) (
    input  logic                  clk,
    input  logic                  reset_,
    input  logic                  reset_sw,
    input  logic                  locked,
    output logic                  dcm_reset,
    output logic [NUM_DOMAIN-1:0] domain_reset_,
    output logic                  all_ready,
    output logic [CNT_W-1:0]      lock_loss_cnt,
    output logic [2:0]            seq_state
);

    localparam int RST_W = clog2(DCM_RST_CYC + 1);
    localparam int STB_W = clog2(LOCK_STABLE + 1);
    localparam int TO_W  = clog2(LOCK_TIMEOUT + 1);
    localparam int STG_W = clog2(STAGGER + 1);
    localparam int IDX_W = clog2(NUM_DOMAIN + 1);

    localparam logic [RST_W-1:0] RST_LAST = RST_W'(DCM_RST_CYC - 1);
    localparam logic [STB_W-1:0] STB_LAST = STB_W'(LOCK_STABLE - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(LOCK_TIMEOUT - 1);
    localparam logic [STG_W-1:0] STG_LAST = STG_W'(STAGGER - 1);
    localparam logic [IDX_W-1:0] IDX_DONE = IDX_W'(NUM_DOMAIN);

    logic sw_req;
    logic lock_s;

    sync_debounce #(.DEBOUNCE(DEBOUNCE)) u_sw_sync (
        .clk   (clk),
        .rst_n (reset_),
        .din   (reset_sw),
        .dout  (sw_req)
    );

    sync_debounce #(.DEBOUNCE(0)) u_lock_sync (
        .clk   (clk),
        .rst_n (reset_),
        .din   (locked),
        .dout  (lock_s)
    );

    seq_state_t            state,    state_nxt;
    logic [RST_W-1:0]      rst_cnt,  rst_cnt_nxt;
    logic [STB_W-1:0]      stab_cnt, stab_cnt_nxt;
    logic [TO_W-1:0]       to_cnt,   to_cnt_nxt;
    logic [STG_W-1:0]      st_cnt,   st_cnt_nxt;
    logic [IDX_W-1:0]      idx,      idx_nxt;
    logic [NUM_DOMAIN-1:0] dom_rel,  dom_rel_nxt;
    logic [CNT_W-1:0]      loss_cnt, loss_cnt_nxt;

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state    <= DCM_RST;
            rst_cnt  <= '0;
            stab_cnt <= '0;
            to_cnt   <= '0;
            st_cnt   <= '0;
            idx      <= '0;
            dom_rel  <= {NUM_DOMAIN{RESET_ENABLE}};
            loss_cnt <= '0;
        end else begin
            state    <= state_nxt;
            rst_cnt  <= rst_cnt_nxt;
            stab_cnt <= stab_cnt_nxt;
            to_cnt   <= to_cnt_nxt;
            st_cnt   <= st_cnt_nxt;
            idx      <= idx_nxt;
            dom_rel  <= dom_rel_nxt;
            loss_cnt <= loss_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        rst_cnt_nxt  = rst_cnt;
        stab_cnt_nxt = stab_cnt;
        to_cnt_nxt   = to_cnt;
        st_cnt_nxt   = st_cnt;
        idx_nxt      = idx;
        dom_rel_nxt  = dom_rel;
        loss_cnt_nxt = loss_cnt;

        case (state)
            DCM_RST: begin
                dom_rel_nxt = {NUM_DOMAIN{RESET_ENABLE}};
                if (sw_req) begin
                    rst_cnt_nxt = '0;
                end else if (rst_cnt == RST_LAST) begin
                    state_nxt    = WAIT_LOCK;
                    rst_cnt_nxt  = '0;
                    stab_cnt_nxt = '0;
                    to_cnt_nxt   = '0;
                end else begin
                    rst_cnt_nxt = rst_cnt + 1'b1;
                end
            end

            WAIT_LOCK: begin
                // Qualification wins over a timeout landing on the same cycle.
                if (sw_req) begin
                    state_nxt   = DCM_RST;
                    rst_cnt_nxt = '0;
                end else if (lock_s && (stab_cnt == STB_LAST)) begin
                    state_nxt  = RELEASE;
                    st_cnt_nxt = '0;
                    idx_nxt    = '0;
                end else if (to_cnt == TO_LAST) begin
                    state_nxt   = DCM_RST;
                    rst_cnt_nxt = '0;
                end else begin
                    to_cnt_nxt   = to_cnt + 1'b1;
                    stab_cnt_nxt = lock_s ? stab_cnt + 1'b1 : '0;
                end
            end

            RELEASE, RUN: begin
                // Lock loss takes precedence so a coincident switch request
                // still records the loss exactly once.
                if (!lock_s || sw_req) begin
                    state_nxt   = DCM_RST;
                    rst_cnt_nxt = '0;
                    dom_rel_nxt = {NUM_DOMAIN{RESET_ENABLE}};
                    if (!lock_s && (loss_cnt != {CNT_W{1'b1}})) begin
                        loss_cnt_nxt = loss_cnt + 1'b1;
                    end
                end else if (state == RELEASE) begin
                    // RUN is entered one cycle after the last domain opens.
                    if (idx == IDX_DONE) begin
                        state_nxt = RUN;
                    end else if (st_cnt == STG_LAST) begin
                        dom_rel_nxt = dom_rel | (NUM_DOMAIN'(1) << idx);
                        idx_nxt     = idx + 1'b1;
                        st_cnt_nxt  = '0;
                    end else begin
                        st_cnt_nxt = st_cnt + 1'b1;
                    end
                end
            end

            default: begin
                state_nxt   = DCM_RST;
                rst_cnt_nxt = '0;
                dom_rel_nxt = {NUM_DOMAIN{RESET_ENABLE}};
            end
        endcase
    end

    assign dcm_reset     = (state == DCM_RST);
    assign all_ready     = (state == RUN);
    assign domain_reset_ = dom_rel;
    assign lock_loss_cnt = loss_cnt;
    assign seq_state     = state;

endmodule
